// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop synchroniser, debounce counter and
// press/long/repeat tracking FSM per channel, with a shared any-event flag.

module key_debounce_chan #(
   parameter int ACTIVE_LOW    = 1,
   parameter int DEB_CYCLES    = 1000000,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int REPEAT_EN     = 1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_short,
   output logic key_long,
   output logic key_repeat
);
   localparam logic REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam int   HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int   DW       = $clog2(DEB_CYCLES);
   localparam int   HW       = $clog2(HOLD_MAX);
   localparam logic [DW-1:0] DEB_TERM  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] LONG_TERM = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {REL, PRS, HLD} state_t;

   logic [1:0]    sync;
   logic          key_sync;
   logic          commit;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;
   state_t        state;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sync <= {2{REL_LVL}};
      else            sync <= {sync[0], key};
   end

   assign key_sync = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
   assign commit   = (key_sync != key_state) && (deb_cnt == DEB_TERM);

   // Any sample matching the committed level restarts the debounce window.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         deb_cnt   <= '0;
         key_state <= 1'b0;
      end else if (key_sync == key_state) begin
         deb_cnt <= '0;
      end else if (commit) begin
         deb_cnt   <= '0;
         key_state <= key_sync;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // Release commit outranks a coincident long/repeat terminal count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= REL;
         hold_cnt    <= '0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_short   <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_short   <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
         case (state)
            REL: begin
               if (commit && key_sync) begin
                  state     <= PRS;
                  hold_cnt  <= '0;
                  key_press <= 1'b1;
               end
            end
            PRS: begin
               if (commit && !key_sync) begin
                  state       <= REL;
                  hold_cnt    <= '0;
                  key_release <= 1'b1;
                  key_short   <= 1'b1;
               end else if (hold_cnt == LONG_TERM) begin
                  state    <= HLD;
                  hold_cnt <= '0;
                  key_long <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            HLD: begin
               if (commit && !key_sync) begin
                  state       <= REL;
                  hold_cnt    <= '0;
                  key_release <= 1'b1;
               end else if (REPEAT_EN != 0) begin
                  if (hold_cnt == REP_TERM) begin
                     hold_cnt   <= '0;
                     key_repeat <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state    <= REL;
               hold_cnt <= '0;
            end
         endcase
      end
   end
endmodule

module key_debounce_multi #(
   parameter int KEY_NUM       = 4,
   parameter int ACTIVE_LOW    = 1,
   parameter int DEB_CYCLES    = 1000000,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int REPEAT_EN     = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_short,
   output logic [KEY_NUM-1:0] key_long,
   output logic [KEY_NUM-1:0] key_repeat,
   output logic               key_flag
);
   for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
      key_debounce_chan #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEB_CYCLES   (DEB_CYCLES),
         .LONG_CYCLES  (LONG_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .REPEAT_EN    (REPEAT_EN)
      ) u_chan (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
         .key        (key[i]),
         .key_state  (key_state[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i]),
         .key_short  (key_short[i]),
         .key_long   (key_long[i]),
         .key_repeat (key_repeat[i])
      );
   end

   // Pulses are registered, so the flag lands in the same cycle as they do.
   assign key_flag = |{key_press, key_release, key_short, key_long, key_repeat};
endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; next generation of the 4-key debounce block.
- Each channel has its own synchroniser, debounce counter and press-tracking FSM.
- Outputs a level-stable key state plus one-cycle event pulses: press, release, short click, long press and auto-repeat.
- Sits between board key pins and UI/control logic (menus, volume, record start/stop) in 50 MHz designs.

Parameters:
- KEY_NUM, 4, number of independent key channels (>=1).
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
- DEB_CYCLES, 1000000, consecutive differing samples needed to commit a state change (20 ms at 50 MHz); >=2.
- LONG_CYCLES, 50000000, pressed cycles before the long-press event (1 s); >=2.
- REPEAT_CYCLES, 10000000, auto-repeat period after long press (200 ms); >=2.
- REPEAT_EN, 1, 1 = generate key_repeat while held after long press; 0 = no repeat.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- key  in  KEY_NUM  raw key pins, asynchronous to sys_clk
- key_state  out  KEY_NUM  debounced level, 1 = pressed
- key_press  out  KEY_NUM  1-cycle pulse on committed press
- key_release  out  KEY_NUM  1-cycle pulse on committed release
- key_short  out  KEY_NUM  1-cycle pulse on release before the long threshold
- key_long  out  KEY_NUM  1-cycle pulse when hold reaches LONG_CYCLES
- key_repeat  out  KEY_NUM  1-cycle pulse every REPEAT_CYCLES in long-hold
- key_flag  out  1  OR of all event pulses over all channels, same cycle as the pulses

Behaviour:
- Reset and clocking
  - One clock, sys_clk. Reset is asynchronous, active-low on sys_rst_n.
  - In reset, the synchroniser flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - In reset, all counters clear to 0, every FSM goes to REL, and every output is 0.
- Synchroniser
  - key_sync = 2-flop synchroniser of key, then normalised so that 1 = pressed (invert when ACTIVE_LOW=1).
- Debounce (per channel)
  - If key_sync == key_state: deb_cnt <= 0.
  - Else if deb_cnt == DEB_CYCLES-1: key_state <= key_sync and deb_cnt <= 0. This is the commit.
  - Else: deb_cnt <= deb_cnt + 1.
  - A commit therefore needs DEB_CYCLES consecutive differing samples; any matching sample restarts the count.
  - Latency from a clean pin edge to the key_state change is 2 + DEB_CYCLES cycles.
- Counter widths
  - Sized by $clog2 of the respective parameter.
  - hold_cnt is shared by the PRS and HLD states, sized for max(LONG_CYCLES, REPEAT_CYCLES).
  - No counter wraps: every counter is reset to 0 at its terminal value.
- FSM per channel: REL, PRS, HLD
  - REL: on press commit -> PRS, key_press=1, hold_cnt=0.
  - PRS: hold_cnt increments each cycle. At hold_cnt == LONG_CYCLES-1 -> HLD, key_long=1, hold_cnt=0.
  - HLD: if REPEAT_EN, hold_cnt increments. At REPEAT_CYCLES-1, key_repeat=1 and hold_cnt=0. If REPEAT_EN=0, hold_cnt stays 0.
  - Release commit in PRS -> REL, key_release=1 and key_short=1 in the same cycle.
  - Release commit in HLD -> REL, key_release=1 only.
  - A release commit takes priority over a coincident long or repeat terminal count: that cycle emits only the release (and short, if in PRS).
- Pulse timing
  - All pulses are registered and high for exactly one cycle.
  - key_press and key_release are coincident with the first cycle of the new key_state value.
  - key_long is asserted LONG_CYCLES cycles after key_press.
  - The first key_repeat comes REPEAT_CYCLES after key_long, then every REPEAT_CYCLES.
- Channels
  - Channels are fully independent; simultaneous events on several channels assert several bits in the same cycle.
  - key_flag is a single cycle whenever any bit pulses.
- Reset mid-operation
  - Reset clears everything immediately (no release pulse is emitted).
  - After reset, a still-held key is seen as a new press after 2 + DEB_CYCLES cycles.

Test Plan (KEY_NUM=4, ACTIVE_LOW=1, DEB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=16, REPEAT_EN=1):
- Reset: hold sys_rst_n=0 with key=4'b0000 -> all outputs 0. After reset release: key_press=4'b1111 exactly 10 cycles later, key_flag=1 for 1 cycle.
- Bounce and glitch: key[0] toggles every 3 cycles for 30 cycles, then a 5-cycle low glitch, then steady low -> exactly one key_press[0], 10 cycles after the last edge. No pulse from the glitch. key_state[0]=1.
- Short click: key[1] low for 25 cycles after the commit, then high -> key_press[1], later key_release[1] and key_short[1] in the same cycle. key_long[1] never asserts.
- Long plus repeat: key[2] held low 100 cycles past the commit -> key_long[2] 40 cycles after key_press[2], key_repeat[2] at +16 and +32 (and so on). On release: key_release[2]=1 and key_short[2]=0.
- Simultaneous channels and priority: key[0] and key[3] pressed in the same cycle -> key_press=4'b1001 in one cycle, key_flag a single pulse. Align the release commit with hold_cnt==39 -> release only, no key_long.
- Reset mid-hold: assert reset while channel 2 is in HLD -> all outputs 0 immediately, no key_release. With key[2] still low after reset deasserts -> key_press[2] after 10 cycles. Repeat with REPEAT_EN=0 -> no key_repeat ever.
